// File: rtl/apb_arbiter_2m.sv
// Two-master to one-slave APB arbiter with round-robin grant, transfer replay
// on the slave port, and timeout abort of hung slave accesses.
module apb_arbiter_2m #(
  parameter int unsigned PADDR_WL = 8,
  parameter int unsigned PDATA_WL = 8,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_psel,
  input  logic                m0_penable,
  input  logic                m0_pwrite,
  input  logic [PADDR_WL-1:0] m0_paddr,
  input  logic [PDATA_WL-1:0] m0_pwdata,
  output logic [PDATA_WL-1:0] m0_prdata,
  output logic                m0_pready,
  output logic                m0_pslverr,
  input  logic                m1_psel,
  input  logic                m1_penable,
  input  logic                m1_pwrite,
  input  logic [PADDR_WL-1:0] m1_paddr,
  input  logic [PDATA_WL-1:0] m1_pwdata,
  output logic [PDATA_WL-1:0] m1_prdata,
  output logic                m1_pready,
  output logic                m1_pslverr,
  output logic                s_psel,
  output logic                s_penable,
  output logic                s_pwrite,
  output logic [PADDR_WL-1:0] s_paddr,
  output logic [PDATA_WL-1:0] s_pwdata,
  input  logic [PDATA_WL-1:0] s_prdata,
  input  logic                s_pready,
  output logic                owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [PADDR_WL-1:0] addr_q, addr_d;
  logic [PDATA_WL-1:0] wdata_q, wdata_d;
  logic [PDATA_WL-1:0] rdata_q, rdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          cnt_inc;
  logic                grant_m1;
  logic                bus_act;
  logic                resp_m0, resp_m1;

  // Grant is decided on psel alone; penable carries no extra information here.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      write_q <= write_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    write_d  = write_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    grant_m1 = (m0_psel && m1_psel) ? ~last_q : m1_psel;
    case (state_q)
      IDLE: begin
        if (m0_psel || m1_psel) begin
          owner_d = grant_m1;
          addr_d  = grant_m1 ? m1_paddr  : m0_paddr;
          write_d = grant_m1 ? m1_pwrite : m0_pwrite;
          wdata_d = grant_m1 ? m1_pwdata : m0_pwdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (s_pready) begin
          rdata_d = write_q ? '0 : s_prdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TO_LIMIT) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_act   = (state_q == SETUP) || (state_q == ACCESS);
    s_psel    = bus_act;
    s_penable = (state_q == ACCESS);
    s_pwrite  = bus_act ? write_q : 1'b0;
    s_paddr   = bus_act ? addr_q  : '0;
    s_pwdata  = bus_act ? wdata_q : '0;
    resp_m0   = (state_q == RESP) && !owner_q;
    resp_m1   = (state_q == RESP) &&  owner_q;
    m0_pready  = resp_m0;
    m0_pslverr = resp_m0 ? err_q   : 1'b0;
    m0_prdata  = resp_m0 ? rdata_q : '0;
    m1_pready  = resp_m1;
    m1_pslverr = resp_m1 ? err_q   : 1'b0;
    m1_prdata  = resp_m1 ? rdata_q : '0;
    owner      = owner_q;
  end

endmodule

// File: tb/tb_apb_arbiter_2m.sv
// Randomized bench for apb_arbiter_2m: two random APB masters and a random-wait
// slave, checked every cycle against a transaction-schedule reference model.
module tb_apb_arbiter_2m;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 15;
  localparam int NCYC = 4000;

  logic clk, reset;
  logic m0_psel, m0_penable, m0_pwrite, m1_psel, m1_penable, m1_pwrite;
  logic [AW-1:0] m0_paddr, m1_paddr, s_paddr;
  logic [DW-1:0] m0_pwdata, m1_pwdata, m0_prdata, m1_prdata, s_pwdata, s_prdata;
  logic m0_pready, m1_pready, m0_pslverr, m1_pslverr;
  logic s_psel, s_penable, s_pwrite, s_pready, owner;

  // Master-side drive state, indexed by master number
  logic          mp_sel[2], mp_en[2], mp_wr[2];
  logic [AW-1:0] mp_addr[2];
  logic [DW-1:0] mp_wdata[2];

  assign m0_psel = mp_sel[0];  assign m1_psel = mp_sel[1];
  assign m0_penable = mp_en[0]; assign m1_penable = mp_en[1];
  assign m0_pwrite = mp_wr[0]; assign m1_pwrite = mp_wr[1];
  assign m0_paddr = mp_addr[0]; assign m1_paddr = mp_addr[1];
  assign m0_pwdata = mp_wdata[0]; assign m1_pwdata = mp_wdata[1];

  apb_arbiter_2m #(.PADDR_WL(AW), .PDATA_WL(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata),
    .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata),
    .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
    .s_pready(s_pready), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: the current transfer is described by its SETUP and RESP cycles
  int setup_c, resp_c, wait_n, acc_n;
  bit own, last_m, t_wr, exp_err;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_rdata, exp_data;
  bit req_prev[2];
  bit rst_prev;
  bit pend[2], hold[2];
  int hold_until[2];

  task automatic new_txn(input int m);
    pend[m]     = 1'b1;
    mp_sel[m]   = 1'b1;
    mp_en[m]    = 1'b0;
    mp_wr[m]    = 1'($urandom);
    mp_addr[m]  = AW'($urandom);
    mp_wdata[m] = DW'($urandom);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      mp_sel[m] = 0; mp_en[m] = 0; mp_wr[m] = 0; mp_addr[m] = '0; mp_wdata[m] = '0;
      pend[m] = 0; hold[m] = 0; hold_until[m] = 0;
    end
    s_pready = 0; s_prdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_psel", s_psel, 0);
    check("rst_s_penable", s_penable, 0);
    check("rst_s_bus", {s_pwrite, s_paddr, s_pwdata}, 0);
    check("rst_m0", {m0_pready, m0_pslverr, m0_prdata}, 0);
    check("rst_m1", {m1_pready, m1_pslverr, m1_prdata}, 0);
    check("rst_owner", owner, 0);

    reset = 1'b0;
    setup_c = -100; resp_c = -100; last_m = 1'b1; own = 1'b0;
    t_wr = 0; t_addr = '0; t_wdata = '0; t_rdata = '0; exp_data = '0; exp_err = 0;
    wait_n = 0; acc_n = 0;
    new_txn(0); new_txn(1);   // simultaneous request straight after reset
    req_prev[0] = 1; req_prev[1] = 1; rst_prev = 0;

    for (cyc = 1; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      // Model: what the arbiter does at the edge that opened this cycle
      if (rst_prev) begin
        setup_c = -100; resp_c = -100; last_m = 1'b1;
      end else begin
        if (cyc - 1 == resp_c) last_m = own;
        if (cyc - 1 > resp_c && (req_prev[0] || req_prev[1])) begin
          own     = (req_prev[0] && req_prev[1]) ? !last_m : req_prev[1];
          t_wr    = mp_wr[own];
          t_addr  = mp_addr[own];
          t_wdata = mp_wdata[own];
          t_rdata = DW'($urandom);
          case ($urandom % 8)
            5: wait_n = TO;          // times out exactly at the limit
            6: wait_n = TO - 1;      // ready on the last allowed cycle
            7: wait_n = TO + 5;
            default: wait_n = int'($urandom % 4);
          endcase
          acc_n    = (wait_n < TO) ? wait_n + 1 : TO;
          exp_err  = (wait_n >= TO);
          exp_data = (!t_wr && !exp_err) ? t_rdata : '0;
          setup_c  = cyc;
          resp_c   = cyc + 1 + acc_n;
        end
      end

      // Slave: ready only on the planned ACCESS cycle, noise everywhere else
      if (cyc > setup_c && cyc < resp_c && (cyc - setup_c - 1) == wait_n) begin
        s_pready = 1'b1;
        s_prdata = t_rdata;
      end else begin
        s_pready = (cyc > setup_c && cyc < resp_c) ? 1'b0 : 1'($urandom);
        s_prdata = DW'($urandom);
      end

      // Compare every output against the schedule
      begin
        bit act, acc, rsp;
        act = (cyc >= setup_c) && (cyc < resp_c);
        acc = (cyc > setup_c) && (cyc < resp_c);
        rsp = (cyc == resp_c);
        check("s_psel", s_psel, act);
        check("s_penable", s_penable, acc);
        check("s_pwrite", s_pwrite, act ? t_wr : 1'b0);
        check("s_paddr", s_paddr, act ? t_addr : '0);
        check("s_pwdata", s_pwdata, act ? t_wdata : '0);
        if (act || rsp) check("owner", owner, own);
        check("m0_pready", m0_pready, rsp && !own);
        check("m0_pslverr", m0_pslverr, (rsp && !own) ? exp_err : 1'b0);
        check("m0_prdata", m0_prdata, (rsp && !own) ? exp_data : '0);
        check("m1_pready", m1_pready, rsp && own);
        check("m1_pslverr", m1_pslverr, (rsp && own) ? exp_err : 1'b0);
        check("m1_prdata", m1_prdata, (rsp && own) ? exp_data : '0);
      end

      // Masters: finish, keep waiting, occasionally abandon, or start new transfers
      for (int m = 0; m < 2; m++) begin
        if (pend[m] && !rst_prev && resp_c == cyc - 1 && own == m) begin
          pend[m] = 0; mp_sel[m] = 0; mp_en[m] = 0;
        end
        if (hold[m] && cyc > hold_until[m]) hold[m] = 0;
        if (pend[m]) mp_en[m] = 1'b1;
        if (pend[m] && own == m && cyc >= setup_c && cyc < resp_c && ($urandom % 10 == 0)) begin
          pend[m] = 0; mp_sel[m] = 0; mp_en[m] = 0;
          hold[m] = 1; hold_until[m] = resp_c;
        end
        if (!pend[m] && !hold[m] && (($urandom % 3 == 0) || (rst_prev && m == 0)))
          new_txn(m);
      end
      if (rst_prev && pend[0] && !pend[1] && !hold[1] && ($urandom % 2 == 0)) new_txn(1);

      // Occasional reset, which also idles both masters
      rst_prev = 1'b0;
      reset = 1'b0;
      if ($urandom % 150 == 0) begin
        reset = 1'b1;
        rst_prev = 1'b1;
        for (int m = 0; m < 2; m++) begin
          pend[m] = 0; hold[m] = 0; mp_sel[m] = 0; mp_en[m] = 0;
        end
      end
      req_prev[0] = pend[0];
      req_prev[1] = pend[1];
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_arbiter_2m.md
Name: apb_arbiter_2m

Overview:
Two-master to one-slave APB arbiter. It lets the I2C slave bridge and a second on-chip APB master (e.g. an LED sequencer) share the single register-bank APB port. It arbitrates round-robin, replays the granted master's transfer on the slave bus, stretches the master with pready, and aborts hung slave accesses with a timeout.

Parameters:
PADDR_WL, 8, APB address width
PDATA_WL, 8, APB data width
TIMEOUT, 15, max ACCESS cycles waiting for s_pready before abort (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m0_psel  in  1  master 0 select
m0_penable  in  1  master 0 enable
m0_pwrite  in  1  master 0 write
m0_paddr  in  PADDR_WL  master 0 address
m0_pwdata  in  PDATA_WL  master 0 write data
m0_prdata  out  PDATA_WL  master 0 read data
m0_pready  out  1  master 0 ready
m0_pslverr  out  1  master 0 error (timeout)
m1_psel, m1_penable, m1_pwrite, m1_paddr, m1_pwdata, m1_prdata, m1_pready, m1_pslverr: same as m0, for master 1
s_psel  out  1  slave select
s_penable  out  1  slave enable
s_pwrite  out  1  slave write
s_paddr  out  PADDR_WL  slave address
s_pwdata  out  PDATA_WL  slave write data
s_prdata  in  PDATA_WL  slave read data
s_pready  in  1  slave ready
owner  out  1  master currently granted; valid while busy

Behaviour:
- Reset: state=IDLE, last=1 (so m0 wins the first tie), all outputs 0, internal address/data/write/response registers 0, timeout counter 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: sample m0_psel/m1_psel.
  - If only one is high, grant it.
  - If both are high, grant !last.
  - On grant, latch owner, paddr, pwrite and pwdata, then go to SETUP.
- SETUP: s_psel=1, s_penable=0; go to ACCESS; clear timeout counter.
- ACCESS: s_psel=1, s_penable=1.
  - If s_pready=1: capture s_prdata (0 if write), err=0, go to RESP.
  - Else increment counter. When counter reaches TIMEOUT, set err=1, captured data=0, go to RESP.
- RESP: the owner sees mX_pready=1, mX_pslverr=err and mX_prdata=captured data for exactly one cycle. Set last=owner and go to IDLE.
- Latency: master setup at cycle N with s_pready tied 1 gives mX_pready at N+3.
- Pacing: a new grant can be made in the IDLE cycle immediately after RESP, so back-to-back transfers take 4 cycles each.
- Output masking:
  - s_paddr, s_pwdata and s_pwrite are 0 whenever s_psel=0.
  - mX_prdata and mX_pslverr are 0 except in the owner's RESP cycle.
  - The non-owner's pready stays 0 throughout, so a waiting master is held in its access phase.
- Master inputs are not re-sampled after the grant. If the owner drops psel mid-transfer, the slave transfer still completes, the RESP pulse is still issued, and the result is discarded.
- A master must only begin a transfer while idle on its own port. A master whose pready is held low keeps its request pending and is arbitrated at the next IDLE.
- Reset asserted in any state returns to IDLE next cycle with outputs 0. The in-flight slave access is abandoned.
- TIMEOUT counter is 8 bits wide and saturates; it never wraps.

Test Plan:
- Single write: m0 writes addr 0x12 data 0xA5, s_pready=1 -> s_psel high at cycles 1-2, s_penable high at cycle 2 with s_paddr=0x12, s_pwdata=0xA5; m0_pready=1 at cycle 3, m0_pslverr=0.
- Read with wait: m1 reads 0x40, slave holds s_pready=0 for 3 ACCESS cycles then returns 0x3C -> m1_prdata=0x3C with m1_pready one cycle after s_pready; m0_pready stays 0.
- Contention: m0 and m1 request in the same cycle after reset -> m0 is served first, then m1. Repeat the simultaneous request -> m0 first again (last=1 after m1). With m0 requesting continuously, grants alternate m0, m1, m0.
- Timeout: s_pready tied 0, TIMEOUT=15 -> ACCESS lasts 15 cycles, then mX_pready=1, mX_pslverr=1, prdata=0x00. The next transfer proceeds normally.
- Reset mid-access: assert reset during ACCESS -> next cycle s_psel=0, s_penable=0, all pready=0. A subsequent simultaneous request is granted to m0.
- Owner abandons: m0 drops psel during SETUP -> slave access still completes and the RESP cycle still occurs. m1's pending request is granted in the following IDLE.
